uart_tx_serializer: RTL

Byte-to-serial UART transmitter. It takes the one-cycle tx_ready/tx_data byte strobes issued by the UART control block and drives the serial TXD line as 8N1 frames, or 8E1/8O1 frames when parity is enabled. A small FIFO absorbs bursts, so the control block can fire several bytes faster than the line rate.

---
 rtl/uart_tx_serializer_if.sv | 13 +
 rtl/uart_tx_serializer.sv | 92 +++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte strobe in from the control block, serial line and FIFO status out
interface uart_tx_serializer_if;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       txd;
   logic       busy;
   logic       fifo_full;
   logic       fifo_empty;
   logic       overflow;
   logic       tx_done;
   modport master (output tx_ready, tx_data, input txd, busy, fifo_full, fifo_empty, overflow, tx_done);
   modport slave (input tx_ready, tx_data, output txd, busy, fifo_full, fifo_empty, overflow, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-buffered 8N1/8E1/8O1 UART transmitter with registered txd
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 4,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input logic clk,
   input logic rst,
   uart_tx_serializer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t         r_state, w_state_next;
   logic [7:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wp, r_rp, w_wp_next, w_rp_next;
   logic           r_full, r_empty, r_overflow, r_txd, r_par;
   logic [BW-1:0]  r_baud;
   logic [2:0]     r_bit;
   logic [7:0]     r_shift, w_shift_next, w_head;
   logic           w_tick, w_pop, w_push, w_txd_next, w_done, w_busy;
   assign w_tick       = r_baud == BW'(CLKS_PER_BIT - 1);
   assign w_head       = r_mem[r_rp[AW-1:0]];
   // a pop happens from IDLE or on the final stop-bit edge, giving back-to-back frames
   assign w_pop        = !r_empty && (r_state == IDLE || (r_state == STOP && w_tick));
   assign w_push       = bus.tx_ready && (!r_full || w_pop);
   assign w_wp_next    = r_wp + PW'(w_push);
   assign w_rp_next    = r_rp + PW'(w_pop);
   assign w_shift_next = w_pop ? w_head : (r_state == DATA && w_tick) ? {1'b0, r_shift[7:1]} : r_shift;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_state_next;
   end
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_pop) w_state_next = START;
         START:   if (w_tick) w_state_next = DATA;
         DATA:    if (w_tick && r_bit == 3'd7) w_state_next = PARITY_EN ? PARITY : STOP;
         PARITY:  if (w_tick) w_state_next = STOP;
         STOP:    if (w_tick) w_state_next = w_pop ? START : IDLE;
         default: w_state_next = IDLE;
      endcase
   end
   // txd is computed from the next state so the registered line changes on the same edge as the state
   always_comb begin
      w_txd_next = (w_state_next == START) ? 1'b0 : (w_state_next == DATA) ? w_shift_next[0] : (w_state_next == PARITY) ? r_par : 1'b1;
      w_done     = r_state == STOP && w_tick;
      w_busy     = r_state != IDLE || !r_empty;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         r_baud  <= (w_pop || r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
         r_bit   <= (r_state == DATA) ? r_bit + {2'b0, w_tick} : 3'd0;
         r_shift <= w_shift_next;
         if (w_pop) r_par <= ^w_head ^ PARITY_ODD;
         r_txd   <= w_txd_next;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wp    <= w_wp_next;
         r_rp    <= w_rp_next;
         r_full  <= (w_wp_next - w_rp_next) == PW'(FIFO_DEPTH);
         r_empty <= w_wp_next == w_rp_next;
         if (bus.tx_ready && !w_push) r_overflow <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= bus.tx_data;
   end
   assign bus.txd        = r_txd;
   assign bus.busy       = w_busy;
   assign bus.fifo_full  = r_full;
   assign bus.fifo_empty = r_empty;
   assign bus.overflow   = r_overflow;
   assign bus.tx_done    = w_done;
endmodule
